// File: rtl/mul_div_pkg.sv
// Shared types for the iterative HI/LO multiply/divide unit.
package mul_div_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic {
        MD_IDLE,
        MD_RUN
    } md_state_t;

endpackage

// File: rtl/mul_div_if.sv
// EX-stage request bundle and HI/LO / stall results of the mul/div unit.
interface mul_div_if #(
    parameter int WIDTH = 32
);
    import mul_div_pkg::*;

    logic             start;
    muldiv_op_t       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, src_a, src_b, input busy, hi, lo);
    modport slave  (input start, op, src_a, src_b, output busy, hi, lo);

endinterface

// File: rtl/mul_div_step.sv
// One iteration on {acc, opr}: shift-add multiply step or restoring divide step.
module mul_div_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] opr_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] opr_o
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, acc_i} + {1'b0, m_i};
        shifted = {acc_i, opr_i[WIDTH-1]};
        diff    = shifted - {1'b0, m_i};
        if (is_div_i) begin
            // remainder < divisor keeps diff[WIDTH] a valid borrow flag
            if (!diff[WIDTH]) begin
                acc_o = diff[WIDTH-1:0];
                opr_o = {opr_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = shifted[WIDTH-1:0];
                opr_o = {opr_i[WIDTH-2:0], 1'b0};
            end
        end else if (opr_i[0]) begin
            {acc_o, opr_o} = {sum, opr_i[WIDTH-1:1]};
        end else begin
            {acc_o, opr_o} = {1'b0, acc_i, opr_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: FSM, counter, sign fix-up and HI/LO registers.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    mul_div_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, mq_q, mq_d, m_q, m_d, a_q, a_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic [WIDTH-1:0] step_acc, step_opr;
    logic [2*WIDTH-1:0] prod;
    logic             sgn;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? -x : x;
    endfunction

    mul_div_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (div_q),
        .acc_i    (acc_q),
        .opr_i    (mq_q),
        .m_i      (m_q),
        .acc_o    (step_acc),
        .opr_o    (step_opr)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        m_d     = m_q;
        a_d     = a_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        sgn     = (bus.op == MD_MULT) || (bus.op == MD_DIV);
        prod    = {step_acc, step_opr};
        if (neg_q) prod = -prod;
        case (state_q)
            MD_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        MD_MTHI: hi_d = bus.src_a;
                        MD_MTLO: lo_d = bus.src_a;
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            div_d   = (bus.op == MD_DIV) || (bus.op == MD_DIVU);
                            neg_d   = sgn && (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
                            rneg_d  = sgn && bus.src_a[WIDTH-1];
                            dz_d    = (bus.src_b == '0);
                            a_d     = bus.src_a;
                            acc_d   = '0;
                            mq_d    = mag(bus.src_a, sgn);
                            m_d     = mag(bus.src_b, sgn);
                            cnt_d   = '0;
                            state_d = MD_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            MD_RUN: begin
                acc_d = step_acc;
                mq_d  = step_opr;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                    if (!div_q) begin
                        {hi_d, lo_d} = prod;
                    end else if (dz_q) begin
                        // divide by zero returns the raw dividend in HI, no trap
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        lo_d = neg_q  ? -step_opr : step_opr;
                        hi_d = rneg_q ? -step_acc : step_acc;
                    end
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            m_q     <= '0;
            a_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            m_q     <= m_d;
            a_q     <= a_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.busy = (state_q == MD_RUN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed bench for mul_div_unit against a behavioural HI/LO model.
module tb_mul_div_unit;
    import mul_div_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    bit   cmp_en = 1'b0;

    always #5 clk = ~clk;

    mul_div_if #(.WIDTH(W)) bus ();

    mul_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Behavioural model: results from plain integer arithmetic.
    logic        m_busy = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] pend = '0;
    int          m_left = 0;

    function automatic logic [63:0] ref_op(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, rm;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (o)
            MD_MULT:  r = sa * sb;
            MD_MULTU: r = {32'b0, a} * {32'b0, b};
            MD_DIV: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r  = {rm[31:0], q[31:0]};
                end
            end
            MD_DIVU: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: r = '0;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0; m_hi <= '0; m_lo <= '0; m_left <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_hi   <= pend[63:32];
                m_lo   <= pend[31:0];
            end
        end else if (bus.start) begin
            if (bus.op == MD_MTHI) m_hi <= bus.src_a;
            else if (bus.op == MD_MTLO) m_lo <= bus.src_a;
            else if (bus.op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}) begin
                pend   <= ref_op(bus.op, bus.src_a, bus.src_b);
                m_left <= W;
                m_busy <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", {31'b0, bus.busy}, {31'b0, m_busy});
            chk("hi",   bus.hi, m_hi);
            chk("lo",   bus.lo, m_lo);
        end
    end

    task automatic issue(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (bus.busy) chk("timeout", 32'd1, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] c [5];
        c[0] = 32'h0; c[1] = 32'h1; c[2] = 32'hFFFF_FFFF; c[3] = 32'h8000_0000; c[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        int n;
        reset = 1'b1;
        bus.start = 1'b0; bus.op = MD_MULT; bus.src_a = '0; bus.src_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        reset = 1'b0;
        cmp_en = 1'b1;

        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(n);
        chk("multu_busy_cycles", n, 32'd32);
        chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
        chk("multu_lo", bus.lo, 32'h0000_0001);

        issue(MD_MULT, -32'sd3, 32'd5); wait_idle(n);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFF1);

        issue(MD_DIV, -32'sd7, 32'd2); wait_idle(n);
        chk("div_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_hi", bus.hi, 32'hFFFF_FFFF);

        issue(MD_DIVU, 32'd100, 32'd7); wait_idle(n);
        chk("divu_lo", bus.lo, 32'h0000_000E);
        chk("divu_hi", bus.hi, 32'h0000_0002);

        issue(MD_DIVU, 32'd5, 32'd0); wait_idle(n);
        chk("divz_lo", bus.lo, 32'hFFFF_FFFF);
        chk("divz_hi", bus.hi, 32'h0000_0005);

        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle(n);
        chk("ovf_lo", bus.lo, 32'h8000_0000);
        chk("ovf_hi", bus.hi, 32'h0000_0000);

        @(negedge clk);
        bus.start = 1'b1; bus.op = MD_MTHI; bus.src_a = 32'h1234_5678;
        @(negedge clk);
        chk("mthi", bus.hi, 32'h1234_5678);
        chk("mthi_busy", {31'b0, bus.busy}, 32'd0);
        bus.op = MD_MTLO; bus.src_a = 32'h9ABC_DEF0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("mtlo", bus.lo, 32'h9ABC_DEF0);
        chk("mtlo_busy", {31'b0, bus.busy}, 32'd0);

        issue(MD_DIVU, 32'd100, 32'd7);
        repeat (8) @(negedge clk);
        bus.start = 1'b1; bus.op = MD_MTLO; bus.src_a = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle(n);
        chk("ign_lo", bus.lo, 32'h0000_000E);
        chk("ign_hi", bus.hi, 32'h0000_0002);

        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (13) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
        chk("midrst_hi", bus.hi, 32'd0);
        chk("midrst_lo", bus.lo, 32'd0);
        issue(MD_MULTU, 32'd6, 32'd7); wait_idle(n);
        chk("after_rst_lo", bus.lo, 32'd42);
        chk("after_rst_hi", bus.hi, 32'd0);

        for (int i = 0; i < 200; i++) begin
            issue(muldiv_op_t'(3'($urandom_range(0, 5))), pick(), pick());
            if (bus.busy && $urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(0, 20)) @(negedge clk);
                bus.start = 1'b1; bus.op = muldiv_op_t'(3'($urandom_range(0, 5)));
                bus.src_a = $urandom; bus.src_b = $urandom;
                @(negedge clk);
                bus.start = 1'b0;
            end
            wait_idle(n);
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative HI/LO multiply/divide unit in the EX stage, serving MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- A multiply or divide is issued as a one-cycle start pulse from EX and runs for WIDTH cycles.
- While it runs, `busy` is the stall request into the hazard unit, so the block is the producer end of the stall interface.
- The hazard unit holds any MFHI/MFLO in D, and any further mul/div, until `busy` falls.
- `hi`/`lo` feed the MFHI/MFLO read path.

Parameters:
WIDTH, 32, operand width and iteration count (one result bit per cycle).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle op request from EX. Caller drives it only for a valid, non-flushed EX instruction.
- op  input  3  muldiv_op_t: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- src_a  input  WIDTH  rs value (multiplicand or dividend; MTHI/MTLO data).
- src_b  input  WIDTH  rt value (multiplier or divisor).
- busy  output  1  high while an iterative op is in flight. Feeds hazard-unit stall.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high on `reset`.
- Reset values: state=IDLE, busy=0, hi=0, lo=0, counter=0, all internal operand and accumulator registers 0.
- Reset mid-operation: abandon the op, return to IDLE, clear hi/lo. Partial results are never written.
- State machine:
  - IDLE: busy=0.
  - start with MULT/MULTU/DIV/DIVU: latch operands, go to RUN.
  - start with MTHI: write src_a to hi in the same edge, stay IDLE.
  - start with MTLO: write src_a to lo in the same edge, stay IDLE.
  - RUN: busy=1; one iteration per cycle; counter runs 0..WIDTH-1. At counter==WIDTH-1, write final hi/lo and go to IDLE.
- Latency:
  - start accepted at edge 0.
  - busy is high for exactly WIDTH cycles (cycles 1..WIDTH).
  - New hi/lo are visible in cycle WIDTH+1, the same cycle busy is 0.
  - busy is a registered function of state; no combinational path from start.
- hi/lo during RUN: hold their old values and change only at completion.
- start while RUN: ignored entirely (no latch, no MTHI/MTLO write). The hazard unit guarantees this does not happen; the bench checks that it is harmless.
- Signed ops (MULT, DIV):
  - Take magnitudes of src_a and src_b and run the unsigned core.
  - Product sign = sign(a) XOR sign(b). Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
  - Negate on completion as required.
- Multiply: shift-add over the 2*WIDTH product. hi = product[2W-1:W], lo = product[W-1:0].
- Divide: restoring, one quotient bit per cycle MSB first. lo = quotient, hi = remainder.
- Divide by zero (any signedness): lo = all ones, hi = src_a (raw, unmodified). No exception is raised.
- Overflow for DIV of -2^(W-1) / -1: lo = 0x80000000, hi = 0 (wrap). Not trapped.

Decomposition:
- Package mul_div_pkg: muldiv_op_t enum (MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5), state enum md_state_t {MD_IDLE, MD_RUN}.
- One sub-module, mul_div_step: purely combinational single iteration (shift-add or restore-subtract) on {acc, operand}.
- Top holds the FSM, counter, sign fix-up and hi/lo registers.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy high exactly 32 cycles, then hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/7 -> lo=0x0000000E, hi=0x00000002. DIVU 5/0 -> lo=0xFFFFFFFF, hi=0x00000005.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on back-to-back cycles -> hi/lo updated the next edge each, busy never rises.
- DIVU 100/7 started, then MTLO 0xDEADBEEF pulsed at cycle 10 -> ignored; final lo=0x0000000E, hi=0x00000002.
- MULTU started, reset asserted at cycle 15 for 1 cycle -> busy=0 and hi=lo=0 from the next cycle; a subsequent MULTU 6*7 gives lo=42, hi=0.
